// File: rtl/sc_stream_decoder.sv
// sc_stream_decoder: counts 1s in a unipolar stochastic bitstream over a window of 2^N valid samples.
//   clock, reset (async, active-high); start begins a window; bit_in/bit_valid carry the stream;
//   busy is high while accumulating; res_valid/res_ready hand off res_ones (0..2^N) and
//   res_bip (signed 2*res_ones - 2^N).
module sc_stream_decoder #(
    parameter int N = 12
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic         bit_in,
    input  logic         bit_valid,
    output logic         busy,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [N:0]   res_ones,
    output logic [N+1:0] res_bip
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [N+1:0] HALF = {2'b01, N'(0)};

    logic [1:0]   state;
    logic [N:0]   ones_cnt;
    logic [N:0]   ones_nxt;
    logic [N-1:0] samp_cnt;

    assign ones_nxt = ones_cnt + (N+1)'(bit_in);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            res_valid <= 1'b0;
            ones_cnt  <= '0;
            samp_cnt  <= '0;
            res_ones  <= '0;
            res_bip   <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    state    <= ACCUM;
                    busy     <= 1'b1;
                    ones_cnt <= '0;
                    samp_cnt <= '0;
                end
                ACCUM: if (start) begin
                    // restart discards this cycle's sample
                    ones_cnt <= '0;
                    samp_cnt <= '0;
                end else if (bit_valid) begin
                    ones_cnt <= ones_nxt;
                    samp_cnt <= samp_cnt + 1'b1;
                    if (&samp_cnt) begin
                        res_ones  <= ones_nxt;
                        res_bip   <= {ones_nxt, 1'b0} - HALF;
                        state     <= DONE;
                        busy      <= 1'b0;
                        res_valid <= 1'b1;
                    end
                end
                DONE: if (res_ready) begin
                    res_valid <= 1'b0;
                    state     <= start ? ACCUM : IDLE;
                    busy      <= start;
                    ones_cnt  <= '0;
                    samp_cnt  <= '0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_stream_decoder.sv
// tb_sc_stream_decoder: directed self-checking bench for sc_stream_decoder with N=4 (window of 16).
module tb_sc_stream_decoder;
    localparam int N = 4;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         bit_in = 1'b0;
    logic         bit_valid = 1'b0;
    logic         res_ready = 1'b0;
    logic         busy;
    logic         res_valid;
    logic [N:0]   res_ones;
    logic [N+1:0] res_bip;

    int errors = 0;
    int checks = 0;

    sc_stream_decoder #(.N(N)) dut (
        .clock(clock), .reset(reset), .start(start), .bit_in(bit_in), .bit_valid(bit_valid),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready), .res_ones(res_ones), .res_bip(res_bip)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [N+1:0] bip_of(input int ones);
        return (N+2)'(2 * ones - 16);
    endfunction

    task automatic begin_window;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy after start", 32'(busy), 1);
    endtask

    // feed 16 valid samples pat[0] first; check exact result latency and values
    task automatic feed_and_check(input string name, input logic [15:0] pat, input int exp_ones);
        bit_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bit_in = pat[i];
            tick();
            if (i == 14) chk({name, " valid early"}, 32'(res_valid), 0);
        end
        bit_valid = 1'b0;
        bit_in = 1'b0;
        chk({name, " valid"}, 32'(res_valid), 1);
        chk({name, " busy done"}, 32'(busy), 0);
        chk({name, " ones"}, 32'(res_ones), 32'(exp_ones));
        chk({name, " bip"}, 32'(res_bip), 32'(bip_of(exp_ones)));
    endtask

    task automatic consume(input string name, input int exp_ones);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        chk({name, " valid cleared"}, 32'(res_valid), 0);
        chk({name, " idle not busy"}, 32'(busy), 0);
        chk({name, " ones held"}, 32'(res_ones), 32'(exp_ones));
    endtask

    task automatic test_reset;
        reset = 1'b1;
        tick();
        chk("rst busy", 32'(busy), 0);
        chk("rst valid", 32'(res_valid), 0);
        chk("rst ones", 32'(res_ones), 0);
        chk("rst bip", 32'(res_bip), 0);
        reset = 1'b0;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        tick();
        tick();
        bit_valid = 1'b0;
        chk("idle ignores valid", 32'(busy), 0);
    endtask

    task automatic test_all_ones_zeros_alt;
        begin_window();
        feed_and_check("all1", 16'hFFFF, 16);
        consume("all1", 16);
        begin_window();
        feed_and_check("all0", 16'h0000, 0);
        consume("all0", 0);
        begin_window();
        feed_and_check("alt", 16'h5555, 8);
        consume("alt", 8);
    endtask

    task automatic test_vdc_random_valid;
        logic [3:0] vdc;
        int k = 0;
        int cyc = 0;
        begin_window();
        while (k < 16 && cyc < 300) begin
            if (cyc < 40 ? ($urandom_range(0, 1) == 1) : 1'b1) begin
                vdc = {k[0], k[1], k[2], k[3]};
                bit_valid = 1'b1;
                bit_in = (5 > vdc);
                k++;
            end else begin
                bit_valid = 1'b0;
                bit_in = 1'b1;
            end
            tick();
            cyc++;
        end
        bit_valid = 1'b0;
        bit_in = 1'b0;
        chk("vdc samples delivered", 32'(k), 16);
        chk("vdc valid", 32'(res_valid), 1);
        chk("vdc ones", 32'(res_ones), 5);
        chk("vdc bip", 32'(res_bip), 32'(bip_of(5)));
    endtask

    task automatic test_backpressure;
        bit_valid = 1'b1;
        bit_in = 1'b1;
        start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp valid held", 32'(res_valid), 1);
            chk("bp ones stable", 32'(res_ones), 5);
            chk("bp bip stable", 32'(res_bip), 32'(bip_of(5)));
            chk("bp not busy", 32'(busy), 0);
        end
        bit_valid = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        start = 1'b0;
        chk("bp direct accum busy", 32'(busy), 1);
        chk("bp direct accum valid", 32'(res_valid), 0);
        feed_and_check("bp next", 16'h00F3, 6);
        consume("bp next", 6);
    endtask

    task automatic test_restart;
        begin_window();
        bit_valid = 1'b1;
        bit_in = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart busy", 32'(busy), 1);
        feed_and_check("restart", 16'h000F, 4);
        consume("restart", 4);
    endtask

    task automatic test_async_reset;
        begin_window();
        bit_valid = 1'b1;
        bit_in = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("areset busy", 32'(busy), 0);
        chk("areset valid", 32'(res_valid), 0);
        chk("areset ones", 32'(res_ones), 0);
        chk("areset bip", 32'(res_bip), 0);
        bit_valid = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        begin_window();
        feed_and_check("post reset", 16'hFFFF, 16);
        consume("post reset", 16);
    endtask

    initial begin
        test_reset();
        test_all_ones_zeros_alt();
        test_vdc_random_valid();
        test_backpressure();
        test_restart();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
